// File: rtl/tf_norm_mul.sv
// Weight normalizer: multiplies a signed Q10.21 weight by an unsigned Q11.20 inverse norm.
// It uses a fixed 3-stage pipeline that never stalls, feeding a credit-guarded output FIFO.
module tf_norm_mul #(
  parameter int DEPTH  = 4,
  parameter int NUM_IN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [32*NUM_IN-1:0] IBUS,
  input  logic                 IVALID,
  output logic                 IREADY,
  output logic [31:0]          OBUS,
  output logic                 OVALID,
  input  logic                 OREADY,
  output logic                 SAT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  // Control state (reset)
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic          v3_q, v3_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovalid_q, ovalid_d;
  logic          sat_q, sat_d;

  // Datapath state (no reset)
  logic [31:0]        w1_q, w1_d;
  logic [31:0]        inv1_q, inv1_d;
  logic signed [63:0] p2_q, p2_d;
  logic [31:0]        r3_q, r3_d;
  logic               sat3_q, sat3_d;
  logic [31:0]        mem_q [DEPTH];

  logic               accept;
  logic               push;
  logic               pop;
  logic [CW+1:0]      used;
  logic signed [63:0] w_ext;
  logic signed [63:0] v_ext;
  logic [12:0]        p_hi;
  logic               no_ovf;
  logic               unused_p2_lo;

  // Every beat in flight already owns a FIFO slot, so the pipeline can run freely.
  always_comb begin
    used   = {2'b00, cnt_q}
           + {{(CW+1){1'b0}}, v1_q}
           + {{(CW+1){1'b0}}, v2_q}
           + {{(CW+1){1'b0}}, v3_q};
    IREADY = (used < DEPTH_W);
    accept = IVALID & IREADY;
    push   = v3_q;
    pop    = ovalid_q & OREADY;
  end

  // S1 capture and S2 full-precision product
  always_comb begin
    v1_d   = accept;
    w1_d   = accept ? IBUS[63:32] : w1_q;
    inv1_d = accept ? IBUS[31:0]  : inv1_q;
    w_ext  = {{32{w1_q[31]}}, w1_q};
    v_ext  = {32'd0, inv1_q};
    p2_d   = w_ext * v_ext;
    v2_d   = v1_q;
  end

  // S3: keep P[51:20] when the top 13 bits agree, otherwise clamp by sign.
  always_comb begin
    p_hi         = p2_q[63:51];
    no_ovf       = (&p_hi) | ~(|p_hi);
    unused_p2_lo = ^p2_q[19:0];
    v3_d         = v2_q;
    sat3_d       = ~no_ovf;
    if (no_ovf) begin
      r3_d = p2_q[51:20];
    end else if (p2_q[63]) begin
      r3_d = 32'h8000_0000;
    end else begin
      r3_d = 32'h7FFF_FFFF;
    end
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovalid_d = (cnt_d != '0);
    sat_d    = sat_q | (v3_q & sat3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
      sat_q    <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    w1_q   <= w1_d;
    inv1_q <= inv1_d;
    p2_q   <= p2_d;
    r3_q   <= r3_d;
    sat3_q <= sat3_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (push && (wptr_q == AW'(gi))) begin
          mem_q[gi] <= r3_q;
        end
      end
    end
  endgenerate

  assign OBUS   = mem_q[rptr_q];
  assign OVALID = ovalid_q;
  assign SAT    = sat_q;

endmodule

// File: tb/tb_tf_norm_mul.sv
// Bench for tf_norm_mul: directed vector table, flow-control sequences and random traffic.
// A cycle-level scoreboard model checks every output on each falling edge.
module tb_tf_norm_mul;
  localparam int DEPTH = 4;
  localparam int unsigned NEVER = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] IBUS;
  logic        IVALID;
  logic        IREADY;
  logic [31:0] OBUS;
  logic        OVALID;
  logic        OREADY;
  logic        SAT;

  always #5 clk = ~clk;

  tf_norm_mul #(.DEPTH(DEPTH), .NUM_IN(2)) dut (
    .clk(clk), .rst(rst), .IBUS(IBUS), .IVALID(IVALID), .IREADY(IREADY),
    .OBUS(OBUS), .OVALID(OVALID), .OREADY(OREADY), .SAT(SAT)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int n_pop  = 0;
  int unsigned edge_cnt = 0;
  int unsigned sat_due  = NEVER;

  typedef struct { logic [31:0] r; int unsigned wr_edge; } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Real-valued product W*V scaled to Q10.21, floored, then clamped to 32-bit range.
  function automatic logic [31:0] ref_mul(input logic [31:0] w, input logic [31:0] v,
                                          output bit sat);
    longint p, q;
    p = longint'($signed(w)) * longint'({32'd0, v});
    q = p >>> 20;
    sat = 1'b1;
    if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (q < -64'sd2147483648) return 32'h8000_0000;
    sat = 1'b0;
    return 32'(q);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s @edge %0d: got %08h expected %08h", name, edge_cnt, got, want);
    end
  endtask

  logic        mon_ov;
  logic [31:0] mon_r;
  bit          mon_s;
  exp_t        mon_e;

  // Transfers are decided by the values held during the low phase before the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sat_due = NEVER;
    end else begin
      check("iready", {31'd0, IREADY}, {31'd0, exp_q.size() < DEPTH});
      mon_ov = (exp_q.size() > 0) && (exp_q[0].wr_edge <= edge_cnt);
      check("ovalid", {31'd0, OVALID}, {31'd0, mon_ov});
      check("sat", {31'd0, SAT}, {31'd0, edge_cnt >= sat_due});
      if (mon_ov && OREADY) begin
        check("obus", OBUS, exp_q[0].r);
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (IVALID && IREADY) begin
        mon_r = ref_mul(IBUS[63:32], IBUS[31:0], mon_s);
        mon_e.r = mon_r;
        mon_e.wr_edge = edge_cnt + 4;
        exp_q.push_back(mon_e);
        if (mon_s && (edge_cnt + 4 < sat_due)) sat_due = edge_cnt + 4;
      end
    end
  end

  typedef struct { logic [31:0] w; logic [31:0] v; logic [31:0] r; bit sat; } vec_t;
  vec_t        tbl[11];
  logic [31:0] bw[6];
  bit          any_sat;
  bit          rdy;
  int          lat;
  int          idx;
  int          cyc;
  int          p0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_beat();
    logic [31:0] w, v;
    case ($urandom_range(0, 7))
      0:       w = 32'h7FFF_FFFF;
      1:       w = 32'h8000_0000;
      2:       w = $urandom_range(0, 32'h00FF_FFFF);
      default: w = $urandom;
    endcase
    v = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h003F_FFFF))
                                    : ($urandom & 32'h7FFF_FFFF);
    return {w, v};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h0020_0000, 32'h0008_0000, 32'h0010_0000, 1'b0};
    tbl[1]  = '{32'hFFC0_0000, 32'h0030_0000, 32'hFF40_0000, 1'b0};
    tbl[2]  = '{32'hFFFF_FFFF, 32'h0008_0000, 32'hFFFF_FFFF, 1'b0};
    tbl[3]  = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[4]  = '{32'h0000_0003, 32'h0008_0000, 32'h0000_0001, 1'b0};
    tbl[5]  = '{32'hFFFF_FFFD, 32'h0008_0000, 32'hFFFF_FFFE, 1'b0};
    tbl[6]  = '{32'h7FFF_FFFF, 32'h0010_0000, 32'h7FFF_FFFF, 1'b0};
    tbl[7]  = '{32'h8000_0000, 32'h0010_0000, 32'h8000_0000, 1'b0};
    tbl[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    tbl[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[10] = '{32'h4000_0000, 32'h0020_0000, 32'h7FFF_FFFF, 1'b1};

    rst = 1'b1; IVALID = 1'b0; OREADY = 1'b0; IBUS = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ovalid", {31'd0, OVALID}, 32'd0);
    check("reset_sat", {31'd0, SAT}, 32'd0);
    check("reset_iready", {31'd0, IREADY}, 32'd1);

    // Directed table: one beat at a time, latency and value checked explicitly.
    any_sat = 1'b0;
    OREADY = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      IBUS = {tbl[i].w, tbl[i].v};
      IVALID = 1'b1;
      check("tbl_iready", {31'd0, IREADY}, 32'd1);
      step();
      IVALID = 1'b0;
      lat = 0;
      while (!OVALID && lat < 10) begin
        step();
        lat++;
      end
      check("tbl_latency", lat, 3);
      check("tbl_obus", OBUS, tbl[i].r);
      any_sat |= tbl[i].sat;
      check("tbl_sat", {31'd0, SAT}, {31'd0, any_sat});
    end
    repeat (3) step();

    // Backpressure: six distinct beats against a stalled consumer.
    for (int i = 0; i < 6; i++) bw[i] = 32'h0000_1000 * (i + 1) + i;
    OREADY = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      IBUS = {bw[idx < 6 ? idx : 5], 32'h0010_0000};
      IVALID = (idx < 6);
      rdy = IREADY;
      step();
      if (rdy && idx < 6) idx++;
    end
    check("bp_accepted", idx, 4);
    check("bp_iready_low", {31'd0, IREADY}, 32'd0);
    p0 = n_pop;
    OREADY = 1'b1;
    cyc = 0;
    while ((n_pop - p0) < 6 && cyc < 60) begin
      IBUS = {bw[idx < 6 ? idx : 5], 32'h0010_0000};
      IVALID = (idx < 6);
      rdy = IREADY;
      step();
      if (rdy && idx < 6) idx++;
      cyc++;
    end
    IVALID = 1'b0;
    check("bp_total_accepted", idx, 6);
    check("bp_popped", n_pop - p0, 6);
    repeat (3) step();

    // Full FIFO, then continuous input and output; 4 credits over a 5-cycle loop.
    OREADY = 1'b0;
    IVALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      IBUS = rand_beat();
      step();
    end
    check("conc_full_iready", {31'd0, IREADY}, 32'd0);
    OREADY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      IBUS = rand_beat();
      step();
    end
    p0 = n_pop;
    for (int c = 0; c < 20; c++) begin
      IBUS = rand_beat();
      step();
    end
    check("conc_rate_ok", {31'd0, (n_pop - p0) >= 16}, 32'd1);
    IVALID = 1'b0;
    repeat (10) step();

    // Reset with two results stored and two beats still in the pipeline.
    OREADY = 1'b0;
    IVALID = 1'b1;
    for (int c = 0; c < 4; c++) begin
      IBUS = rand_beat();
      step();
    end
    IVALID = 1'b0;
    step();
    rst = 1'b1;
    IVALID = 1'b1;
    IBUS = {32'h0020_0000, 32'h0010_0000};
    OREADY = 1'b1;
    step();
    rst = 1'b0;
    IVALID = 1'b0;
    check("mrst_ovalid", {31'd0, OVALID}, 32'd0);
    check("mrst_iready", {31'd0, IREADY}, 32'd1);
    check("mrst_sat", {31'd0, SAT}, 32'd0);
    p0 = n_pop;
    repeat (10) step();
    check("mrst_no_stale", n_pop - p0, 0);

    // Random traffic with occasional reset pulses.
    for (int c = 0; c < 800; c++) begin
      IBUS = rand_beat();
      IVALID = ($urandom_range(0, 9) < 7);
      OREADY = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    IVALID = 1'b0;
    OREADY = 1'b1;
    repeat (20) step();
    check("drain_empty", exp_q.size(), 0);
    check("drain_ovalid", {31'd0, OVALID}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
